// File: rtl/key_debounce_pkg.sv
// Shared constants for the front-panel key conditioner.
// State encodings and board timing defaults.
package key_debounce_pkg;

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam int CLK_HZ    = 50_000_000;
  localparam int CYC_10MS  = CLK_HZ / 100;
  localparam int CYC_500MS = CLK_HZ / 2;
  localparam int CYC_100MS = CLK_HZ / 10;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_sync.sv
// Reset-to-released synchroniser for one raw key input.
// Kept as discrete flops so tools do not pack it into an SRL.
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* shreg_extract = "no", ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Debounced press/release/auto-repeat events for one key.
// All outputs registered; key_n only reaches them via key_sync.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = CYC_10MS,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = CYC_500MS,
  parameter int REPEAT_PERIOD = CYC_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CMAX = max3(
    STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] STB_LAST =
    CW'(STABLE_CYCLES - 1);
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  logic          key_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  key_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_n),
    .q  (key_s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RELEASED;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        ST_RELEASED: begin
          if (!key_s) begin
            if (ONE_SHOT) begin
              state       <= ST_HELD;
              cnt         <= '0;
              pressed     <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              state <= ST_PRESS_CHK;
              cnt   <= CW'(1);
            end
          end
        end
        ST_PRESS_CHK: begin
          if (key_s) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state       <= ST_HELD;
            cnt         <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HELD: begin
          if (key_s) begin
            if (ONE_SHOT) begin
              state         <= ST_RELEASED;
              cnt           <= '0;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              state <= ST_RELEASE_CHK;
              cnt   <= CW'(1);
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (!key_s) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ST_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  if (REPEAT_DELAY > 0) begin : g_rep
    localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);

    logic [CW-1:0] rcnt;
    logic [CW-1:0] rinc;
    logic [CW-1:0] rtgt;
    logic          rphase;

    assign rinc = (rcnt == '1) ? rcnt : rcnt + 1'b1;
    assign rtgt = rphase ? PER : DLY;

    // Frozen in RELEASE_CHK so a release bounce keeps cadence.
    always_ff @(posedge clk) begin
      if (rst) begin
        rcnt         <= '0;
        rphase       <= 1'b0;
        repeat_pulse <= 1'b0;
      end else begin
        repeat_pulse <= 1'b0;
        if (state == ST_HELD) begin
          if (rinc == rtgt) begin
            rcnt         <= '0;
            rphase       <= 1'b1;
            repeat_pulse <= 1'b1;
          end else begin
            rcnt <= rinc;
          end
        end else if (state != ST_RELEASE_CHK) begin
          rcnt   <= '0;
          rphase <= 1'b0;
        end
      end
    end
  end else begin : g_norep
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce, with and without auto-repeat.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst;
  logic key_n;

  logic p1, pp1, rp1, rep1;
  logic p0, pp0, rp0, rep0;

  int nchk  = 0;
  int npass = 0;

  typedef struct {
    logic rst;
    logic key_n;
    logic e_pressed;
    logic e_press;
    logic e_release;
    logic e_repeat;
  } vec_t;

  vec_t tbl [0:127];

  always #5 clk = ~clk;

  key_debounce #(
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .pressed      (p1),
    .press_pulse  (pp1),
    .release_pulse(rp1),
    .repeat_pulse (rep1)
  );

  key_debounce #(
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2),
    .REPEAT_DELAY (0),
    .REPEAT_PERIOD(3)
  ) dut0 (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .pressed      (p0),
    .press_pulse  (pp0),
    .release_pulse(rp0),
    .repeat_pulse (rep0)
  );

  task automatic chk(
    input string nm,
    input int    cyc,
    input logic  act,
    input logic  exp
  );
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s cycle %0d: got %b want %b",
                  nm, cyc, act, exp);
  endtask

  task automatic chk_int(
    input string nm,
    input int    act,
    input int    exp
  );
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_tbl(
    input string nm,
    input int    n
  );
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      chk({nm, ".pressed"}, c, p1, tbl[c].e_pressed);
      chk({nm, ".press"}, c, pp1, tbl[c].e_press);
      chk({nm, ".release"}, c, rp1, tbl[c].e_release);
      chk({nm, ".repeat"}, c, rep1, tbl[c].e_repeat);
      chk({nm, ".nr_pressed"}, c, p0, tbl[c].e_pressed);
      chk({nm, ".nr_press"}, c, pp0, tbl[c].e_press);
      chk({nm, ".nr_release"}, c, rp0, tbl[c].e_release);
      chk({nm, ".nr_repeat"}, c, rep0, 1'b0);
      rst   = tbl[c].rst;
      key_n = tbl[c].key_n;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;

    // Clean press, auto-repeat, release glitch, release.
    for (int c = 0; c < 52; c++) begin
      tbl[c].rst       = 1'b0;
      tbl[c].key_n     = (c >= 30 && c < 32) || c >= 40;
      tbl[c].e_pressed = c >= 6 && c <= 45;
      tbl[c].e_press   = c == 6;
      tbl[c].e_release = c == 46;
      tbl[c].e_repeat  =
        (c >= 16 && c <= 31 && (c - 16) % 3 == 0) ||
        c == 36 || c == 39 || c == 42;
    end
    run_tbl("hold", 52);

    // Reset mid-hold, key still down.
    for (int c = 0; c < 32; c++) begin
      tbl[c].rst       = c == 12;
      tbl[c].key_n     = 1'b0;
      tbl[c].e_pressed = (c >= 6 && c <= 12) || c >= 19;
      tbl[c].e_press   = c == 6 || c == 19;
      tbl[c].e_release = 1'b0;
      tbl[c].e_repeat  = c == 29;
    end
    run_tbl("rst", 32);

    // Long hold, repeat-less instance must stay quiet.
    for (int c = 0; c < 110; c++) begin
      tbl[c].rst       = 1'b0;
      tbl[c].key_n     = c >= 100;
      tbl[c].e_pressed = c >= 6 && c <= 105;
      tbl[c].e_press   = c == 6;
      tbl[c].e_release = c == 106;
      tbl[c].e_repeat  =
        c >= 16 && c <= 103 && (c - 16) % 3 == 0;
    end
    run_tbl("long", 110);

    // Bounce: 3 low / 1 high x5, then held low from 20.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      @(posedge clk);
      #1;
      chk("bounce.press", c, pp1, 1'b0);
      chk("bounce.pressed", c, p1, 1'b0);
      rst   = 1'b0;
      key_n = (c < 20) ? (c % 4 == 3) : 1'b0;
    end
    hit = -1;
    for (int c = 21; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (pp1) begin
        hit = c;
        break;
      end
      chk("bounce.wait_pressed", c, p1, 1'b0);
    end
    chk_int("bounce.latency", hit, 26);
    chk("bounce.pressed_at_hit", hit, p1, 1'b1);
    chk("bounce.nr_press_at_hit", hit, pp0, 1'b1);
    @(posedge clk);
    #1;
    chk("bounce.press_single", hit + 1, pp1, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
